vit_frame_ctrl: RTL and testbench

Frame sequencer between the serial convolutional-encoder symbol stream and the PipeViterbi decoder. It packs 2-bit encoded symbols into 16-bit decoder words, issues them to the decoder over a valid/ready handshake, and appends zero tail (flush) words to terminate each frame. It also tracks the decoder pipeline latency so each decoded byte is emitted with a valid strobe. This replaces free-running clock division and fixed-cadence paralleling with explicit framing.

---
 rtl/vit_pkg.sv | 21 ++
 rtl/vit_lat_tracker.sv | 35 +++
 rtl/vit_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_vit_frame_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// Shared types and widths for the Viterbi frame sequencer.
package vit_pkg;

  localparam int unsigned SYM_PER_WORD = 8;
  localparam int unsigned WORD_W       = 16;
  localparam int unsigned DEC_W        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic valid;
    logic data;
    logic last;
  } tag_t;

endpackage

// File: rtl/vit_lat_tracker.sv
// Decoder latency tracker: DEC_LAT-deep tag shift register with tail tag and empty flag.
module vit_lat_tracker
  import vit_pkg::*;
#(
  parameter int unsigned DEC_LAT = 6
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic empty_c
);

  tag_t pipe [DEC_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEC_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEC_LAT-1];

  // Empty once no valid tag remains anywhere in the pipe
  always_comb begin
    empty_c = 1'b1;
    for (int i = 0; i < DEC_LAT; i++) begin
      if (pipe[i].valid) empty_c = 1'b0;
    end
  end

endmodule

// File: rtl/vit_frame_ctrl.sv
// Frame sequencer: packs 2-bit symbols into 16-bit decoder words, appends flush words
// and strobes decoded bytes once the decoder pipeline latency has elapsed.
module vit_frame_ctrl
  import vit_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = 4,
  parameter int unsigned FLUSH_WORDS     = 1,
  parameter int unsigned DEC_LAT         = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  input  logic [DEC_W-1:0]  dec_in,
  output logic [DEC_W-1:0]  dec_out,
  output logic              dec_valid,
  output logic              dec_last,
  output logic              busy,
  output logic              frame_done,
  output logic              start_err
);

  localparam int unsigned IDX_W  = $clog2(SYM_PER_WORD);
  localparam int unsigned WCNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam int unsigned FCNT_W = $clog2(FLUSH_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYM_PER_WORD - 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    sym_idx;
  logic [WCNT_W-1:0]   word_cnt;
  logic [FCNT_W-1:0]   flush_cnt;
  logic [WORD_W-3:0]   asm_q;
  logic                word_is_data, word_dlast;
  logic                hs, sym_acc, ld_data, ld_flush, done_nxt;
  tag_t                tag_in, tag_tail;
  logic                lat_empty;

  assign hs        = word_valid && word_ready;
  assign sym_ready = (state == FILL) && ((sym_idx != IDX_LAST) || !word_valid || word_ready);
  assign sym_acc   = sym_valid && sym_ready;

  // Next state and per-cycle load strobes
  always_comb begin
    state_nxt = state;
    ld_data   = 1'b0;
    ld_flush  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        if (sym_acc && (sym_idx == IDX_LAST)) begin
          ld_data = 1'b1;
          if (word_cnt == WCNT_W'(WORDS_PER_FRAME - 1)) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if ((flush_cnt != FCNT_W'(FLUSH_WORDS)) && (!word_valid || hs)) ld_flush = 1'b1;
        if (hs && word_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (lat_empty) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = hs;
    tag_in.data  = hs && word_is_data;
    tag_in.last  = hs && word_dlast;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sym_idx      <= '0;
      word_cnt     <= '0;
      flush_cnt    <= '0;
      asm_q        <= '0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      word_last    <= 1'b0;
      word_is_data <= 1'b0;
      word_dlast   <= 1'b0;
      dec_out      <= '0;
      dec_valid    <= 1'b0;
      dec_last     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= done_nxt;
      if (start && (state != IDLE)) start_err <= 1'b1;

      if ((state == IDLE) && start) begin
        sym_idx   <= '0;
        word_cnt  <= '0;
        flush_cnt <= '0;
      end

      // Symbol k lands in bits [2k+1:2k]; the 8th symbol completes the word directly
      if (sym_acc) begin
        for (int k = 0; k < SYM_PER_WORD - 1; k++) begin
          if (sym_idx == IDX_W'(k)) asm_q[2*k +: 2] <= sym_in;
        end
        sym_idx <= sym_idx + IDX_W'(1);
      end

      // Hold register: a load on the handshake edge keeps word_valid high without a bubble
      if (ld_data) begin
        word_out     <= {sym_in, asm_q};
        word_valid   <= 1'b1;
        word_last    <= 1'b0;
        word_is_data <= 1'b1;
        word_dlast   <= (word_cnt == WCNT_W'(WORDS_PER_FRAME - 1));
        word_cnt     <= word_cnt + WCNT_W'(1);
      end else if (ld_flush) begin
        word_out     <= '0;
        word_valid   <= 1'b1;
        word_last    <= (flush_cnt == FCNT_W'(FLUSH_WORDS - 1));
        word_is_data <= 1'b0;
        word_dlast   <= 1'b0;
        flush_cnt    <= flush_cnt + FCNT_W'(1);
      end else if (hs) begin
        word_valid <= 1'b0;
        word_last  <= 1'b0;
      end

      if (tag_tail.valid && tag_tail.data) dec_out <= dec_in;
      dec_valid <= tag_tail.valid && tag_tail.data;
      dec_last  <= tag_tail.valid && tag_tail.data && tag_tail.last;
    end
  end

  vit_lat_tracker #(
    .DEC_LAT (DEC_LAT)
  ) u_lat (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_tail),
    .empty_c (lat_empty)
  );

endmodule

// File: tb/tb_vit_frame_ctrl.sv
// Directed bench for vit_frame_ctrl: default configuration plus a 1-word / 2-flush / latency-1 instance.
module tb_vit_frame_ctrl;

  localparam int unsigned LAT  = 6;
  localparam int unsigned LAT2 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [1:0]  sym_in;
  logic        sym_valid;
  logic        sym_ready, sym_ready2;
  logic [15:0] word_out, word_out2;
  logic        word_valid, word_valid2, word_ready, word_ready2, word_last, word_last2;
  logic [7:0]  dec_in, dec_out, dec_out2;
  logic        dec_valid, dec_valid2, dec_last, dec_last2;
  logic        busy, busy2, frame_done, frame_done2, start_err, start_err2;

  int n_checks = 0;
  int n_fail   = 0;
  int sym_timeouts = 0;
  int cyc = 0;

  int          hs_cyc[$],  dv_cyc[$],  fd_cyc[$];
  logic [15:0] hs_word[$];
  logic        hs_last[$], dv_last[$];
  logic [7:0]  dv_data[$];
  int          hs2_cyc[$], dv2_cyc[$], fd2_cyc[$];
  logic [15:0] hs2_word[$];
  logic        hs2_last[$], dv2_last[$];
  logic [7:0]  dv2_data[$];

  always #5 clk = ~clk;

  vit_frame_ctrl #(.WORDS_PER_FRAME(4), .FLUSH_WORDS(1), .DEC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .word_last(word_last), .dec_in(dec_in), .dec_out(dec_out),
    .dec_valid(dec_valid), .dec_last(dec_last), .busy(busy), .frame_done(frame_done),
    .start_err(start_err)
  );

  vit_frame_ctrl #(.WORDS_PER_FRAME(1), .FLUSH_WORDS(2), .DEC_LAT(LAT2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready2), .word_out(word_out2), .word_valid(word_valid2),
    .word_ready(word_ready2), .word_last(word_last2), .dec_in(dec_in), .dec_out(dec_out2),
    .dec_valid(dec_valid2), .dec_last(dec_last2), .busy(busy2), .frame_done(frame_done2),
    .start_err(start_err2)
  );

  // Decoder byte seen at edge k is dec_model(k)
  function automatic logic [7:0] dec_model(input int k);
    return 8'(k * 7 + 3);
  endfunction

  function automatic logic [31:0] outs1();
    return {word_out, word_valid, word_last, dec_out, dec_valid, dec_last,
            busy, frame_done, start_err, sym_ready};
  endfunction

  function automatic logic [31:0] outs2();
    return {word_out2, word_valid2, word_last2, dec_out2, dec_valid2, dec_last2,
            busy2, frame_done2, start_err2, sym_ready2};
  endfunction

  // Event log sampled at each rising edge, before that edge's updates
  always @(posedge clk) begin
    if (word_valid && word_ready) begin
      hs_cyc.push_back(cyc); hs_word.push_back(word_out); hs_last.push_back(word_last);
    end
    if (dec_valid) begin
      dv_cyc.push_back(cyc); dv_data.push_back(dec_out); dv_last.push_back(dec_last);
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if (word_valid2 && word_ready2) begin
      hs2_cyc.push_back(cyc); hs2_word.push_back(word_out2); hs2_last.push_back(word_last2);
    end
    if (dec_valid2) begin
      dv2_cyc.push_back(cyc); dv2_data.push_back(dec_out2); dv2_last.push_back(dec_last2);
    end
    if (frame_done2) fd2_cyc.push_back(cyc);
    cyc <= cyc + 1;
  end

  initial begin
    dec_in = 8'h00;
    forever begin
      @(negedge clk);
      dec_in = dec_model(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    hs_cyc.delete();  hs_word.delete();  hs_last.delete();
    dv_cyc.delete();  dv_data.delete();  dv_last.delete();  fd_cyc.delete();
    hs2_cyc.delete(); hs2_word.delete(); hs2_last.delete();
    dv2_cyc.delete(); dv2_data.delete(); dv2_last.delete(); fd2_cyc.delete();
  endtask

  task automatic send_sym(input logic [1:0] s, input bit sel, output int waited);
    waited = 0;
    sym_in = s;
    sym_valid = 1'b1;
    while (!(sel ? sym_ready2 : sym_ready) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) sym_timeouts++;
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit sel);
    int wt;
    for (int k = 0; k < 8; k++) send_sym(w[2*k +: 2], sel, wt);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int n = 0;
    while ((sel ? fd2_cyc.size() : fd_cyc.size()) == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  // Full-frame check for the default instance: 4 data words then one flush word
  task automatic check_frame(input logic [15:0] w0, w1, w2, w3);
    logic [15:0] exp_w [5];
    exp_w = '{w0, w1, w2, w3, 16'h0000};
    check("hs_count", hs_cyc.size(), 5);
    for (int i = 0; i < 5 && i < hs_cyc.size(); i++)
      check($sformatf("word%0d", i), {15'b0, hs_last[i], hs_word[i]},
            {15'b0, (i == 4), exp_w[i]});
    if (hs_cyc.size() == 5) check("flush_b2b", hs_cyc[4] - hs_cyc[3], 1);
    check("dv_count", dv_cyc.size(), 4);
    for (int i = 0; i < 4 && i < dv_cyc.size() && i < hs_cyc.size(); i++) begin
      check($sformatf("dv_lat%0d", i), dv_cyc[i] - hs_cyc[i], LAT + 1);
      check($sformatf("dv_data%0d", i), {dv_last[i], dv_data[i]},
            {(i == 3), dec_model(dv_cyc[i] - 1)});
    end
    check("fd_count", fd_cyc.size(), 1);
    if (fd_cyc.size() == 1 && hs_cyc.size() == 5)
      check("fd_lat", fd_cyc[0] - hs_cyc[4], LAT + 2);
    check("idle_after", {busy, sym_ready, word_valid, word_last}, 0);
    check("sym_timeouts", sym_timeouts, 0);
  endtask

  initial begin
    int          wt, waits, bad;
    logic [15:0] wb;

    rst = 1'b0; start = 1'b0; start2 = 1'b0; sym_in = 2'b00; sym_valid = 1'b0;
    word_ready = 1'b1; word_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs", outs1(), 32'h0);
    check("rst_outs2", outs2(), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outs", outs1(), 32'h0);

    // Basic frame: symbols 0,1,2,3 repeated give 16'hE4E4 words
    clear_logs();
    pulse_start(1'b0);
    check("busy_fill", {busy, sym_ready}, 2'b11);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 8; k++) send_sym(2'(k % 4), 1'b0, wt);
    wait_done(1'b0);
    check_frame(16'hE4E4, 16'hE4E4, 16'hE4E4, 16'hE4E4);

    // Backpressure after the first word, then release with a same-edge swap
    clear_logs();
    word_ready = 1'b0;
    pulse_start(1'b0);
    send_word(16'h1234, 1'b0);
    check("bp_first", {word_valid, word_out}, {1'b1, 16'h1234});
    wb = 16'hABCD;
    waits = 0;
    for (int k = 0; k < 7; k++) begin
      send_sym(wb[2*k +: 2], 1'b0, wt);
      waits += wt;
    end
    check("bp_early_syms", waits, 0);
    sym_in = wb[15:14];
    sym_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (word_out !== 16'h1234 || word_valid !== 1'b1 || sym_ready !== 1'b0) bad++;
    end
    check("bp_hold", bad, 0);
    check("bp_no_hs", hs_cyc.size(), 0);
    word_ready = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    check("bp_swap", {word_valid, word_out}, {1'b1, 16'hABCD});
    send_word(16'h0F0F, 1'b0);
    send_word(16'h8001, 1'b0);
    wait_done(1'b0);
    check_frame(16'h1234, 16'hABCD, 16'h0F0F, 16'h8001);
    if (hs_cyc.size() >= 2) check("bp_b2b", hs_cyc[1] - hs_cyc[0], 1);

    // start during FILL flags an error but leaves the frame intact
    clear_logs();
    check("err_clear", start_err, 1'b0);
    pulse_start(1'b0);
    send_sym(2'b01, 1'b0, wt);
    send_sym(2'b01, 1'b0, wt);
    start = 1'b1;
    send_sym(2'b01, 1'b0, wt);
    start = 1'b0;
    for (int k = 3; k < 8; k++) send_sym(2'b01, 1'b0, wt);
    check("err_set", {start_err, busy}, 2'b11);
    send_word(16'hC3A5, 1'b0);
    send_word(16'h7E81, 1'b0);
    send_word(16'hFFFF, 1'b0);
    wait_done(1'b0);
    check_frame(16'h5555, 16'hC3A5, 16'h7E81, 16'hFFFF);
    check("err_sticky", start_err, 1'b1);

    // Reset in the middle of the second word
    clear_logs();
    pulse_start(1'b0);
    send_word(16'h2468, 1'b0);
    wb = 16'h9999;
    for (int k = 0; k < 5; k++) send_sym(wb[2*k +: 2], 1'b0, wt);
    rst = 1'b0;
    #1;
    check("midrst_outs", outs1(), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_nodone", fd_cyc.size(), 0);
    check("midrst_idle", outs1(), 32'h0);
    clear_logs();
    pulse_start(1'b0);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    send_word(16'h3333, 1'b0);
    send_word(16'h4444, 1'b0);
    wait_done(1'b0);
    check_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);

    // One data word, two flush words, one cycle of decoder latency
    clear_logs();
    pulse_start(1'b1);
    check("busy2", {busy2, sym_ready2}, 2'b11);
    send_word(16'h5A3C, 1'b1);
    wait_done(1'b1);
    check("hs2_count", hs2_cyc.size(), 3);
    if (hs2_cyc.size() == 3) begin
      check("w2_0", {hs2_last[0], hs2_word[0]}, {1'b0, 16'h5A3C});
      check("w2_1", {hs2_last[1], hs2_word[1]}, {1'b0, 16'h0000});
      check("w2_2", {hs2_last[2], hs2_word[2]}, {1'b1, 16'h0000});
      check("w2_gap", {hs2_cyc[1] - hs2_cyc[0], hs2_cyc[2] - hs2_cyc[1]}, {32'd1, 32'd1});
    end
    check("dv2_count", dv2_cyc.size(), 1);
    if (dv2_cyc.size() == 1 && hs2_cyc.size() >= 1) begin
      check("dv2_lat", dv2_cyc[0] - hs2_cyc[0], LAT2 + 1);
      check("dv2_data", {dv2_last[0], dv2_data[0]}, {1'b1, dec_model(dv2_cyc[0] - 1)});
    end
    check("fd2_count", fd2_cyc.size(), 1);
    if (fd2_cyc.size() == 1 && hs2_cyc.size() == 3)
      check("fd2_lat", fd2_cyc[0] - hs2_cyc[2], LAT2 + 2);
    check("idle2_after", {busy2, word_valid2, start_err2}, 0);
    check("dut1_quiet", hs_cyc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
